// File: rtl/pipe_flow_ctrl.sv
// Front-end sequencing controller: run/step/halt FSM plus load-use and
// jump/branch hazard handling for PC, IF/ID and ID/EX control.
module pipe_flow_ctrl #(
    parameter int unsigned NB_REG       = 5,
    parameter int unsigned DRAIN_CYCLES = 4,
    parameter int unsigned NB_CNT       = 32
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              start_i,
    input  logic              continuous_i,
    input  logic              step_i,
    input  logic              halt_inst_i,
    input  logic              jump_or_branch_i,
    input  logic [NB_REG-1:0] id_rs_i,
    input  logic [NB_REG-1:0] id_rt_i,
    input  logic [NB_REG-1:0] ex_rt_i,
    input  logic              ex_mem_read_i,
    output logic              enable_pc_o,
    output logic              enable_pipe_o,
    output logic              flush_if_id_o,
    output logic              bubble_id_ex_o,
    output logic [2:0]        state_o,
    output logic [NB_CNT-1:0] cycle_count_o,
    output logic [NB_CNT-1:0] stall_count_o
);

    localparam int unsigned DrainW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StRun      = 3'd1,
        StStepWait = 3'd2,
        StStepExec = 3'd3,
        StDrain    = 3'd4,
        StHalted   = 3'd5
    } state_e;

    state_e              state_q, state_d;
    logic [DrainW-1:0]   drain_cnt_q, drain_cnt_d;
    logic [NB_CNT-1:0]   cycle_cnt_q, cycle_cnt_d;
    logic [NB_CNT-1:0]   stall_cnt_q, stall_cnt_d;
    logic                active;
    logic                load_use;

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q     <= StIdle;
            drain_cnt_q <= '0;
            cycle_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
            cycle_cnt_q <= cycle_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Hazards only matter while instructions are actually advancing.
    assign active   = (state_q == StRun) || (state_q == StStepExec);
    assign load_use = active && ex_mem_read_i && (ex_rt_i != '0) &&
                      ((ex_rt_i == id_rs_i) || (ex_rt_i == id_rt_i));

    always_comb begin
        state_d        = state_q;
        drain_cnt_d    = drain_cnt_q;
        enable_pc_o    = 1'b0;
        enable_pipe_o  = 1'b0;
        flush_if_id_o  = 1'b0;
        bubble_id_ex_o = 1'b0;

        if (active) begin
            if (load_use) begin
                bubble_id_ex_o = 1'b1;
            end else begin
                enable_pc_o   = 1'b1;
                enable_pipe_o = 1'b1;
                flush_if_id_o = jump_or_branch_i && !halt_inst_i;
            end
        end

        case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d = continuous_i ? StRun : StStepWait;
                end
            end
            StRun: begin
                if (halt_inst_i && !load_use) begin
                    state_d     = StDrain;
                    drain_cnt_d = DrainW'(DRAIN_CYCLES - 1);
                end
            end
            StStepWait: begin
                if (step_i) begin
                    state_d = StStepExec;
                end
            end
            StStepExec: begin
                // A stalled step is retried until one cycle actually advances.
                if (!load_use) begin
                    if (halt_inst_i) begin
                        state_d     = StDrain;
                        drain_cnt_d = DrainW'(DRAIN_CYCLES - 1);
                    end else begin
                        state_d = StStepWait;
                    end
                end
            end
            StDrain: begin
                enable_pipe_o = 1'b1;
                flush_if_id_o = 1'b1;
                if (drain_cnt_q == '0) begin
                    state_d = StHalted;
                end else begin
                    drain_cnt_d = drain_cnt_q - 1'b1;
                end
            end
            StHalted: begin
                state_d = StHalted;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        cycle_cnt_d = cycle_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if ((active || (state_q == StDrain)) && (cycle_cnt_q != '1)) begin
            cycle_cnt_d = cycle_cnt_q + 1'b1;
        end
        if (load_use && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    assign state_o       = state_q;
    assign cycle_count_o = cycle_cnt_q;
    assign stall_count_o = stall_cnt_q;

endmodule

// File: tb/tb_pipe_flow_ctrl.sv
// Directed-vector bench for pipe_flow_ctrl with hand-computed expectations.
module tb_pipe_flow_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, cont, step, halt, jb, mem_rd;
    logic [4:0]  id_rs, id_rt, ex_rt;
    logic        en_pc, en_pipe, flush, bubble;
    logic [2:0]  state;
    logic [31:0] cyc, stl;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pipe_flow_ctrl #(
        .NB_REG      (5),
        .DRAIN_CYCLES(4),
        .NB_CNT      (32)
    ) dut (
        .clock_i         (clk),
        .reset_i         (rst),
        .start_i         (start),
        .continuous_i    (cont),
        .step_i          (step),
        .halt_inst_i     (halt),
        .jump_or_branch_i(jb),
        .id_rs_i         (id_rs),
        .id_rt_i         (id_rt),
        .ex_rt_i         (ex_rt),
        .ex_mem_read_i   (mem_rd),
        .enable_pc_o     (en_pc),
        .enable_pipe_o   (en_pipe),
        .flush_if_id_o   (flush),
        .bubble_id_ex_o  (bubble),
        .state_o         (state),
        .cycle_count_o   (cyc),
        .stall_count_o   (stl)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1ns after the edge; outputs are sampled 1ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ctl(input string tag, input logic [2:0] st, input logic pc,
                           input logic pp, input logic fl, input logic bb);
        #1;
        check_eq({tag, ".state"},  {29'd0, state},   {29'd0, st});
        check_eq({tag, ".pc"},     {31'd0, en_pc},   {31'd0, pc});
        check_eq({tag, ".pipe"},   {31'd0, en_pipe}, {31'd0, pp});
        check_eq({tag, ".flush"},  {31'd0, flush},   {31'd0, fl});
        check_eq({tag, ".bubble"}, {31'd0, bubble},  {31'd0, bb});
    endtask

    task automatic clear_hazards();
        mem_rd = 0; ex_rt = 0; id_rs = 0; id_rt = 0; jb = 0; halt = 0;
    endtask

    task automatic set_load_use();
        mem_rd = 1; ex_rt = 5'd8; id_rs = 5'd8; id_rt = 5'd3;
    endtask

    initial begin
        rst = 1; start = 0; cont = 0; step = 0;
        clear_hazards();
        tick(); tick();
        rst = 0;
        chk_ctl("reset", 3'd0, 0, 0, 0, 0);
        check_eq("reset.cyc", cyc, 0);
        check_eq("reset.stl", stl, 0);

        // Run mode entry
        start = 1; cont = 1;
        chk_ctl("idle_start", 3'd0, 0, 0, 0, 0);
        tick(); start = 0;
        chk_ctl("run_entry", 3'd1, 1, 1, 0, 0);
        check_eq("run_entry.cyc", cyc, 0);
        tick();
        check_eq("run_cyc1", cyc, 1);

        // Load-use stall
        set_load_use();
        chk_ctl("lu", 3'd1, 0, 0, 0, 1);
        tick();
        check_eq("lu.stl", stl, 1);
        // rt = 0 never stalls
        mem_rd = 1; ex_rt = 0; id_rs = 0; id_rt = 0;
        chk_ctl("lu_r0", 3'd1, 1, 1, 0, 0);
        tick();
        check_eq("lu_r0.stl", stl, 1);
        // Match on rt as well
        mem_rd = 1; ex_rt = 5'd9; id_rs = 5'd1; id_rt = 5'd9; jb = 1;
        chk_ctl("lu_rt_jb", 3'd1, 0, 0, 0, 1);
        tick();
        check_eq("lu_rt_jb.stl", stl, 2);
        clear_hazards(); jb = 1;
        chk_ctl("jb", 3'd1, 1, 1, 1, 0);
        tick(); jb = 0;
        check_eq("run.cyc5", cyc, 5);

        // HALT is held off by a load-use stall
        set_load_use(); halt = 1;
        chk_ctl("halt_lu", 3'd1, 0, 0, 0, 1);
        tick();
        check_eq("halt_lu.stl", stl, 3);
        clear_hazards(); halt = 1; jb = 1;
        chk_ctl("halt_jb", 3'd1, 1, 1, 0, 0);
        tick(); clear_hazards();
        check_eq("drain.cyc0", cyc, 7);
        for (int i = 0; i < 4; i++) begin
            chk_ctl($sformatf("drain%0d", i), 3'd4, 0, 1, 1, 0);
            tick();
        end
        chk_ctl("halted", 3'd5, 0, 0, 0, 0);
        check_eq("halted.cyc", cyc, 11);
        start = 1; cont = 1; set_load_use();
        tick(); tick(); start = 0;
        chk_ctl("halted_start", 3'd5, 0, 0, 0, 0);
        check_eq("halted.cyc_frozen", cyc, 11);
        check_eq("halted.stl_frozen", stl, 3);
        clear_hazards();

        // Step mode
        rst = 1; tick(); rst = 0;
        start = 1; cont = 0;
        tick(); start = 0;
        chk_ctl("step_wait", 3'd2, 0, 0, 0, 0);
        step = 1;
        chk_ctl("step_t", 3'd2, 0, 0, 0, 0);
        tick(); step = 0;
        chk_ctl("step_t1", 3'd3, 1, 1, 0, 0);
        tick();
        chk_ctl("step_t2", 3'd2, 0, 0, 0, 0);
        check_eq("step.cyc", cyc, 1);

        // Step with load-use held for two cycles
        step = 1; tick(); step = 0;
        set_load_use();
        chk_ctl("step_lu0", 3'd3, 0, 0, 0, 1);
        tick();
        chk_ctl("step_lu1", 3'd3, 0, 0, 0, 1);
        tick(); clear_hazards();
        chk_ctl("step_lu_go", 3'd3, 1, 1, 0, 0);
        tick();
        chk_ctl("step_lu_done", 3'd2, 0, 0, 0, 0);
        check_eq("step_lu.stl", stl, 2);
        check_eq("step_lu.cyc", cyc, 4);

        // HALT during a step, then reset in the second drain cycle
        step = 1; tick(); step = 0;
        halt = 1;
        chk_ctl("step_halt", 3'd3, 1, 1, 0, 0);
        tick(); halt = 0;
        chk_ctl("sdrain0", 3'd4, 0, 1, 1, 0);
        tick();
        chk_ctl("sdrain1", 3'd4, 0, 1, 1, 0);
        rst = 1; tick(); rst = 0;
        chk_ctl("drain_reset", 3'd0, 0, 0, 0, 0);
        check_eq("drain_reset.cyc", cyc, 0);
        check_eq("drain_reset.stl", stl, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
